// File: rtl/ad9833_sweep_ctrl.sv
// AD9833 frequency-sweep sequencer feeding the Avalon wrapper write port, one word in flight at a time.
// Optional handshake timeout enabled by defining AD9833_SWEEP_TIMEOUT_EN.
module ad9833_sweep_ctrl #(
  parameter int HS_TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [27:0] start_freq,
  input  logic [27:0] step_freq,
  input  logic [15:0] num_steps,
  input  logic [31:0] dwell_cycles,
  input  logic [1:0]  wave_sel,
  input  logic        sc_in,
  output logic        wr,
  output logic [31:0] wrdata,
  output logic [3:0]  wr_be,
  output logic        busy,
  output logic        done,
  output logic [27:0] cur_freq,
  output logic [15:0] step_idx,
  output logic        error
);
  typedef enum logic [3:0] {
    IDLE, W_RST, W_LSB, W_MSB, W_RUN, DWELL, S_LSB, S_MSB, W_STOP
  } state_t;

  localparam logic [15:0] CTL_RST = 16'h2100;

  if (HS_TIMEOUT < 2) begin : g_bad_timeout
    $error("HS_TIMEOUT must be at least 2");
  end

  state_t      state_q, state_d;
  logic        wait_q, wait_d;
  logic        sc_prev, sc_edge;
  logic [27:0] f_q, step_q, f_next;
  logic [15:0] nsteps_q;
  logic [31:0] dwell_q, dwell_cnt;
  logic [1:0]  wave_q;
  logic        stop_pend, halt;
  logic        issue, go, adv, msb_done, fin, abort, to_hit;
  logic [15:0] word, run_word;

  assign sc_edge  = sc_in & ~sc_prev;
  assign f_next   = f_q + step_q;
  assign halt     = stop_pend | stop;
  assign msb_done = wait_q & sc_edge & ((state_q == W_MSB) | (state_q == S_MSB));

  always_comb begin
    case (wave_q)
      2'd0:    run_word = 16'h2000;
      2'd1:    run_word = 16'h2002;
      2'd2:    run_word = 16'h2028;
      default: run_word = 16'h2020;
    endcase
  end

`ifdef AD9833_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(HS_TIMEOUT);
  logic [TW-1:0] to_cnt;

  assign to_hit = wait_q & ~sc_edge & (to_cnt == TW'(HS_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || !wait_q) to_cnt <= '0;
    else if (!sc_edge)    to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)      error <= 1'b0;
    else if (go)    error <= 1'b0;
    else if (abort) error <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign error  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    issue   = 1'b0;
    word    = CTL_RST;
    go      = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        // a simultaneous stop cancels the start
        if (start && !stop) begin
          state_d = W_RST;
          issue   = 1'b1;
          go      = 1'b1;
        end
      end
      DWELL: begin
        if (halt) begin
          state_d = W_STOP;
          issue   = 1'b1;
        end else if (dwell_cnt <= 32'd1) begin
          issue = 1'b1;
          if (step_idx == nsteps_q) begin
            state_d = W_STOP;
          end else begin
            state_d = S_LSB;
            adv     = 1'b1;
            word    = {2'b01, f_next[13:0]};
          end
        end
      end
      default: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (sc_edge) begin
          wait_d = 1'b0;
          issue  = 1'b1;
          if (state_q == W_STOP) begin
            state_d = IDLE;
            issue   = 1'b0;
            fin     = 1'b1;
          end else if (halt) begin
            state_d = W_STOP;
          end else begin
            case (state_q)
              W_RST:   begin state_d = W_LSB; word = {2'b01, f_q[13:0]};  end
              W_LSB:   begin state_d = W_MSB; word = {2'b01, f_q[27:14]}; end
              W_MSB:   begin state_d = W_RUN; word = run_word;            end
              S_LSB:   begin state_d = S_MSB; word = {2'b01, f_q[27:14]}; end
              W_RUN, S_MSB: begin state_d = DWELL; issue = 1'b0;          end
              default: issue = 1'b0;
            endcase
          end
        end else if (to_hit) begin
          state_d = IDLE;
          wait_d  = 1'b0;
          abort   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= 1'b0;
      sc_prev   <= 1'b0;
      wr        <= 1'b0;
      wrdata    <= '0;
      wr_be     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_freq  <= '0;
      step_idx  <= '0;
      f_q       <= '0;
      step_q    <= '0;
      nsteps_q  <= '0;
      dwell_q   <= '0;
      wave_q    <= '0;
      dwell_cnt <= '0;
      stop_pend <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sc_prev <= sc_in;
      wr      <= issue;
      wr_be   <= issue ? 4'b0011 : 4'b0000;
      done    <= fin;
      if (issue) wrdata <= {16'h0000, word};
      if (go) begin
        f_q      <= start_freq;
        step_q   <= step_freq;
        nsteps_q <= num_steps;
        dwell_q  <= dwell_cycles;
        wave_q   <= wave_sel;
        step_idx <= '0;
        busy     <= 1'b1;
      end else if (fin || abort) begin
        busy <= 1'b0;
      end
      if (adv) begin
        f_q      <= f_next;
        step_idx <= step_idx + 1'b1;
      end
      if (msb_done) cur_freq <= f_q;
      if (state_d == DWELL && state_q != DWELL) dwell_cnt <= dwell_q;
      else if (state_q == DWELL)                dwell_cnt <= dwell_cnt - 32'd1;
      if (state_d == IDLE) stop_pend <= 1'b0;
      else if (stop)       stop_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// Directed bench for ad9833_sweep_ctrl: a table of complete sweeps plus hand-written corner sequences.
module tb_ad9833_sweep_ctrl;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [27:0] start_freq = '0, step_freq = '0;
  logic [15:0] num_steps = '0;
  logic [31:0] dwell_cycles = '0;
  logic [1:0]  wave_sel = '0;
  logic        sc_in;
  logic        wr, busy, done, error;
  logic [31:0] wrdata;
  logic [3:0]  wr_be;
  logic [27:0] cur_freq;
  logic [15:0] step_idx;

  ad9833_sweep_ctrl #(.HS_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .start_freq(start_freq), .step_freq(step_freq), .num_steps(num_steps),
    .dwell_cycles(dwell_cycles), .wave_sel(wave_sel), .sc_in(sc_in),
    .wr(wr), .wrdata(wrdata), .wr_be(wr_be), .busy(busy), .done(done),
    .cur_freq(cur_freq), .step_idx(step_idx), .error(error)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // wrapper model: send_complete rises 5 cycles after each write, held high 2 cycles
  logic sc_auto = 1'b1, sc_m = 1'b0, sc_a = 1'b0;
  int   sc_cnt = 0, sc_hold = 0;
  assign sc_in = sc_auto ? sc_a : sc_m;
  always @(negedge clock) begin
    if (sc_hold > 0) begin sc_hold--; if (sc_hold == 0) sc_a = 1'b0; end
    if (sc_cnt > 0) begin sc_cnt--; if (sc_cnt == 0) begin sc_a = 1'b1; sc_hold = 2; end end
    if (wr === 1'b1) sc_cnt = 5;
  end

  logic [15:0] wq[$];
  int          tq[$];
  logic [27:0] cfq[$];
  logic [27:0] cf_last = '0;
  int ndone = 0, done_cyc = 0, bad_be = 0, bad_done = 0, clr_req = 0, clr_ack = 0;
  always @(negedge clock) begin
    if (clr_req != clr_ack) begin
      wq.delete(); tq.delete(); cfq.delete();
      ndone = 0; bad_be = 0; bad_done = 0; cf_last = cur_freq; clr_ack = clr_req;
    end else begin
      if (wr === 1'b1) begin
        wq.push_back(wrdata[15:0]); tq.push_back(cyc);
        if (wr_be !== 4'b0011 || wrdata[31:16] !== 16'h0) bad_be++;
      end else if (wr_be !== 4'b0000) bad_be++;
      if (done === 1'b1) begin ndone++; done_cyc = cyc; if (busy !== 1'b0) bad_done++; end
      if (cur_freq !== cf_last) begin cfq.push_back(cur_freq); cf_last = cur_freq; end
    end
  end

  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; sc_auto = 1'b1; sc_m = 1'b0;
    tick(8);
    reset = 1'b0; clr_req++;
    tick(3);
  endtask

  int t_start;
  task automatic pulse_start();
    start = 1'b1; t_start = cyc; tick(1); start = 1'b0;
  endtask

  task automatic set_cfg(input logic [27:0] sf, input logic [27:0] st, input logic [15:0] ns,
                         input logic [31:0] dw, input logic [1:0] ws);
    start_freq = sf; step_freq = st; num_steps = ns; dwell_cycles = dw; wave_sel = ws;
  endtask

  task automatic wait_words(input int n, input string nm);
    for (int i = 0; i < 3000 && wq.size() < n; i++) tick(1);
    if (wq.size() < n) begin
      nchk++; nerr++;
      $display("FAIL %s: timed out, words=%0d, required %0d", nm, wq.size(), n);
    end
  endtask

  task automatic wait_done(input int budget, input string nm);
    for (int i = 0; i < budget && ndone == 0; i++) tick(1);
    tick(3);
    chk({nm, "_done_cnt"}, ndone, 1);
  endtask

  typedef struct {
    logic [27:0] sf; logic [27:0] st; logic [15:0] ns; logic [31:0] dw; logic [1:0] ws;
    logic [15:0] w_lsb; logic [15:0] w_msb; logic [15:0] w_run;
    int nwr; int gap; logic [27:0] cur; logic [15:0] idx;
  } vec_t;
  vec_t vt[5];

  initial begin
    int tgt, t_stop, n;
    // gap = write-to-write spacing across the first dwell: 6 handshake clocks + max(dwell,1)
    vt[0] = '{28'h0ABCDEF, 28'h0000010, 16'd0, 32'd10, 2'd1, 16'h4DEF, 16'h42AF, 16'h2002, 5, 16, 28'h0ABCDEF, 16'd0};
    vt[1] = '{28'hFFFFFFF, 28'h0000002, 16'd2, 32'd3,  2'd0, 16'h7FFF, 16'h7FFF, 16'h2000, 9, 9,  28'h0000003, 16'd2};
    vt[2] = '{28'h0004000, 28'h0001000, 16'd3, 32'd0,  2'd2, 16'h4000, 16'h4001, 16'h2028, 11, 7, 28'h0007000, 16'd3};
    vt[3] = '{28'h1234567, 28'h0FFFFFF, 16'd1, 32'd1,  2'd3, 16'h4567, 16'h448D, 16'h2020, 7, 7,  28'h2234566, 16'd1};
    vt[4] = '{28'h0000000, 28'h8000000, 16'd2, 32'd2,  2'd0, 16'h4000, 16'h4000, 16'h2000, 9, 8,  28'h0000000, 16'd2};

    do_reset();
    chk("reset_ctl", {wr, wr_be, busy, done, error}, 0);
    chk("reset_wrdata", wrdata, 0);
    chk("reset_cur_freq", cur_freq, 0);
    chk("reset_step_idx", step_idx, 0);

    foreach (vt[k]) begin
      do_reset();
      set_cfg(vt[k].sf, vt[k].st, vt[k].ns, vt[k].dw, vt[k].ws);
      pulse_start();
      chk($sformatf("v%0d_busy_start", k), busy, 1);
      wait_done(3000, $sformatf("v%0d", k));
      chk($sformatf("v%0d_nwr", k), wq.size(), vt[k].nwr);
      chk($sformatf("v%0d_w_rst", k), wq[0], 16'h2100);
      chk($sformatf("v%0d_w_lsb", k), wq[1], vt[k].w_lsb);
      chk($sformatf("v%0d_w_msb", k), wq[2], vt[k].w_msb);
      chk($sformatf("v%0d_w_run", k), wq[3], vt[k].w_run);
      chk($sformatf("v%0d_w_stop", k), wq[wq.size()-1], 16'h2100);
      chk($sformatf("v%0d_first_wr_lat", k), tq[0] - t_start, 1);
      chk($sformatf("v%0d_dwell_gap", k), tq[4] - tq[3], vt[k].gap);
      chk($sformatf("v%0d_done_lat", k), done_cyc - tq[tq.size()-1], 6);
      chk($sformatf("v%0d_cur_freq", k), cur_freq, vt[k].cur);
      chk($sformatf("v%0d_step_idx", k), step_idx, vt[k].idx);
      chk($sformatf("v%0d_busy_end", k), busy, 0);
      chk($sformatf("v%0d_be_ok", k), bad_be, 0);
      chk($sformatf("v%0d_done_busy", k), bad_done, 0);
    end

    // sweep wrap: cur_freq history and step words
    do_reset();
    set_cfg(28'hFFFFFFF, 28'h0000002, 16'd2, 32'd3, 2'd0);
    pulse_start();
    wait_done(3000, "wrap");
    chk("wrap_cf_cnt", cfq.size(), 3);
    chk("wrap_cf0", cfq[0], 28'hFFFFFFF);
    chk("wrap_cf1", cfq[1], 28'h0000001);
    chk("wrap_cf2", cfq[2], 28'h0000003);
    chk("wrap_s1_lsb", wq[4], 16'h4001);
    chk("wrap_s1_msb", wq[5], 16'h4000);
    chk("wrap_s2_lsb", wq[6], 16'h4003);
    chk("wrap_s2_msb", wq[7], 16'h4000);

    // stop 50 clocks into a long dwell
    do_reset();
    set_cfg(28'h0100000, 28'h0000100, 16'd5, 32'd1000, 2'd2);
    pulse_start();
    wait_words(4, "stop_init");
    tgt = tq[3] + 6 + 49;
    for (int i = 0; i < 300 && cyc < tgt; i++) tick(1);
    chk("stop_busy_before", busy, 1);
    stop = 1'b1; t_stop = cyc; tick(1); stop = 1'b0;
    wait_done(200, "stop");
    chk("stop_nwr", wq.size(), 5);
    chk("stop_word", wq[4], 16'h2100);
    chk("stop_word_lat", tq[4] - t_stop, 1);
    chk("stop_busy_after", busy, 0);
    chk("stop_cur_freq", cur_freq, 28'h0100000);
    chk("stop_step_idx", step_idx, 0);

    // start while busy is ignored; config latched at the accepted start
    do_reset();
    set_cfg(28'h1234567, 28'h0FFFFFF, 16'd1, 32'd20, 2'd3);
    pulse_start(); tick(2);
    start_freq = 28'h0000001; num_steps = 16'd7;
    pulse_start();
    wait_words(4, "busy_init"); tick(10);
    pulse_start();
    wait_done(600, "busy");
    chk("busy_nwr", wq.size(), 7);
    chk("busy_lsb", wq[1], 16'h4567);
    chk("busy_cur_freq", cur_freq, 28'h2234566);
    chk("busy_step_idx", step_idx, 1);

    // start+stop together in IDLE, then stop alone in IDLE
    do_reset();
    set_cfg(28'h0ABCDEF, 28'h0000010, 16'd0, 32'd10, 2'd1);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    tick(20);
    chk("startstop_nwr", wq.size(), 0);
    chk("startstop_busy", busy, 0);
    stop = 1'b1; tick(1); stop = 1'b0; tick(5);
    chk("idle_stop_done", ndone, 0);

    // sc_in already high at wait start is not a completion
    do_reset();
    set_cfg(28'h0ABCDEF, 28'h0, 16'd0, 32'd2, 2'd0);
    sc_auto = 1'b0; sc_m = 1'b0;
    pulse_start();
    sc_m = 1'b1; tick(10);
    chk("schigh_hold", wq.size(), 1);
    sc_m = 1'b0; tick(1); sc_m = 1'b1; tick(2);
    chk("schigh_rise_nwr", wq.size(), 2);
    chk("schigh_rise_word", wq[1], 16'h4DEF);

    // reset mid-sweep
    do_reset();
    set_cfg(28'h0ABCDEF, 28'h0000001, 16'd3, 32'd1000, 2'd0);
    pulse_start();
    wait_words(4, "rst_init"); tick(20);
    chk("rst_busy_before", busy, 1);
    reset = 1'b1; tick(1);
    chk("rst_ctl", {wr, wr_be, busy, done, error}, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_cur_freq", cur_freq, 0);
    chk("rst_step_idx", step_idx, 0);
    tick(2); reset = 1'b0; n = wq.size(); tick(30);
    chk("rst_no_wr", wq.size(), n);
    chk("rst_busy_after", busy, 0);

    // handshake that never completes
    do_reset();
    set_cfg(28'h0ABCDEF, 28'h0, 16'd0, 32'd2, 2'd0);
    sc_auto = 1'b0; sc_m = 1'b0;
    pulse_start();
`ifdef AD9833_SWEEP_TIMEOUT_EN
    tick(16);
    chk("to_before", {busy, error}, 2'b10);
    tick(1);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_nwr", wq.size(), 1);
    chk("to_done", ndone, 0);
    pulse_start();
    chk("to_clear", error, 0);
    chk("to_restart_busy", busy, 1);
`else
    tick(40);
    chk("stall_error", error, 0);
    chk("stall_busy", busy, 1);
    chk("stall_nwr", wq.size(), 1);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ad9833_sweep_ctrl.md
# ad9833_sweep_ctrl

Frequency-sweep sequencer that sits directly upstream of the AD9833 Avalon wrapper and drives its write port. On a start command it programs the DDS (reset, FREQ0 LSB/MSB, waveform release), then steps FREQ0 by a fixed increment a programmed number of times, dwelling a programmed number of clocks at each frequency. It paces itself on the wrapper's send-complete status so only one 16-bit AD9833 word is in flight at a time.

## Interface
- HS_TIMEOUT, 1024, clocks to wait for send-complete before aborting (used only with AD9833_SWEEP_TIMEOUT_EN)
- clock  in  1  system clock; everything is clocked on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start request
- stop  in  1  one-cycle stop request
- start_freq  in  28  initial FREQ0 tuning word
- step_freq  in  28  per-step increment
- num_steps  in  16  number of increments after the initial frequency
- dwell_cycles  in  32  clocks spent at each frequency
- wave_sel  in  2  0 sine, 1 triangle, 2 square, 3 square/2
- sc_in  in  1  send_complete from the wrapper (Q_export[1])
- wr  out  1  write strobe to the wrapper
- wrdata  out  32  [15:0] AD9833 word, [31:16] zero
- wr_be  out  4  byte enables, always 4'b0011 when wr=1
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep or stop sequence completes
- cur_freq  out  28  tuning word last fully written
- step_idx  out  16  current step, 0 = start_freq
- error  out  1  sticky handshake timeout flag, cleared by start

## Operation
- States: IDLE, W_RST, W_LSB, W_MSB, W_RUN, DWELL, S_LSB, S_MSB, W_STOP.
- Each W_/S_ state has two phases:
  - issue: wr=1 for exactly one cycle.
  - wait: hold until a rising edge of sc_in, detected with a registered previous value.
- Words sent:
  - W_RST: 0x2100 (B28=1, RESET=1).
  - W_LSB/S_LSB: 0x4000 | f[13:0].
  - W_MSB/S_MSB: 0x4000 | f[27:14].
  - W_RUN: 0x2000 | mode. Mode is 0x0000 sine, 0x0002 triangle, 0x0028 square, 0x0020 square/2.
  - W_STOP: 0x2100.
- start in IDLE:
  - Latch all configuration inputs.
  - Clear error, set busy, set f=start_freq and step_idx=0.
  - Sequence W_RST→W_LSB→W_MSB→W_RUN→DWELL.
- DWELL:
  - Counter loads dwell_cycles on entry; state lasts max(dwell_cycles,1) clocks.
  - Then, if step_idx==num_steps, go to W_STOP.
  - Otherwise f=f+step_freq (mod 2^28), step_idx+1, go S_LSB→S_MSB→DWELL.
- cur_freq updates when the MSB word's sc_in edge is seen.
- W_STOP: after its completion, pulse done, clear busy, return to IDLE.
- stop while busy:
  - Recorded.
  - Any word in flight completes its handshake; DWELL exits immediately.
  - Then W_STOP, done pulse, IDLE.
- Ignored requests:
  - start while busy.
  - stop in IDLE.
  - start and stop in the same IDLE cycle: stop wins, no sweep.
- Outputs outside issue cycles:
  - wr=0.
  - wrdata holds the last word.
  - wr_be=0.

## Timing
- Reset values: wr=0, wrdata=0, wr_be=0, busy=0, done=0, cur_freq=0, step_idx=0, error=0; state IDLE.
- Reset mid-sweep returns to IDLE next clock; no stop word is sent.
- start sampled at cycle N:
  - busy=1 and the issue phase of W_RST at N+1 (wr=1 at N+1).
  - Wait phase from N+2.
- sc_in edge handling:
  - Edge visible at cycle M (sc_in=1 at M, 0 at M-1): next word's wr=1 at M+1.
  - An sc_in already high when the wait phase starts is not an edge.
- After the last sc_in edge of W_STOP: done=1 for one cycle and busy=0 in that same cycle.
- Step arithmetic is a 28-bit unsigned add; carry is discarded.
- num_steps=0 gives one dwell at start_freq only.
- Total dwell periods = num_steps+1.

## Configuration
- AD9833_SWEEP_TIMEOUT_EN defined:
  - A wait-phase counter aborts when HS_TIMEOUT clocks pass without an sc_in edge.
  - On abort: error=1, busy=0, done=0, return to IDLE with no stop word.
- Undefined: the wait phase is unbounded and error is tied to 0.

## Test plan
- Reset: hold reset 3 cycles mid-sweep → all outputs at reset values next cycle, wr stays 0.
- Init sequence:
  - Stimulus: start_freq=0x0ABCDEF, wave_sel=1, num_steps=0, dwell=10, sc_in pulses 5 cycles after each wr.
  - Required: words 0x2100, 0x4000|0x0DEF... precisely 0x4DEF, 0x42AF, 0x2002, then 10 clocks of dwell, then 0x2100 and a done pulse.
- Sweep wrap:
  - Stimulus: start_freq=0xFFFFFFF, step=2, num_steps=2.
  - Required: cur_freq sequence 0xFFFFFFF, 0x0000001, 0x0000003; step_idx ends at 2.
- Stop mid-dwell: dwell=1000, stop at dwell cycle 50 → next word written is 0x2100, then a done pulse, busy=0.
- Ignored and simultaneous requests:
  - start while busy: no effect.
  - start and stop together in IDLE: wr stays 0.
  - sc_in held high at wait start: no advance until it falls and rises.
- Timeout (AD9833_SWEEP_TIMEOUT_EN, HS_TIMEOUT=16): no sc_in edge → error=1 and busy=0 after 16 wait clocks; the next start clears error.
